// File: rtl/gated_bus_pkg.sv
// gated_bus_pkg: shared defaults and LC-3 bus source indices for gated_bus
package gated_bus_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_NSRC = 4;
  localparam int SRC_MDR = 0;
  localparam int SRC_ALU = 1;
  localparam int SRC_PC = 2;
  localparam int SRC_MARMUX = 3;
endpackage

// File: rtl/gated_bus_prio_enc.sv
// prio_enc: lowest-index-wins priority encoder; gate_i in, idx_o/any_o/multi_o out
module prio_enc #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] gate_i,
  output logic [W-1:0] idx_o,
  output logic         any_o,
  output logic         multi_o
);
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) idx_o = gate_i[i] ? i[W-1:0] : idx_o;
  end
  assign any_o = |gate_i;
  assign multi_o = |(gate_i & (gate_i - 1'b1));
endmodule

// File: rtl/gated_bus.sv
// gated_bus: priority-gated shared bus with keeper, optional output register, sticky contention flag; GATED_BUS_ERRCNT_EN adds saturating err_count
module gated_bus
  import gated_bus_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NSRC = DEF_NSRC,
  parameter int REG_OUT = 0,
  localparam int SW = $clog2(NSRC)
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [NSRC-1:0]            gate,
  input  logic [NSRC-1:0][WIDTH-1:0] src_data,
  input  logic                       err_clr,
  output logic [WIDTH-1:0]           bus_out,
  output logic                       bus_valid,
  output logic [SW-1:0]              sel_idx,
  output logic                       contention,
  output logic                       contention_sticky
`ifdef GATED_BUS_ERRCNT_EN
  ,
  output logic [15:0]                err_count
`endif
);
  logic [SW-1:0] idx_d;
  logic any_d, multi_d;
  logic [WIDTH-1:0] bus_d, keeper_q;
  logic sticky_q;
  prio_enc #(.N(NSRC)) u_enc (
    .gate_i (gate),
    .idx_o  (idx_d),
    .any_o  (any_d),
    .multi_o(multi_d)
  );
  assign bus_d = any_d ? src_data[idx_d] : keeper_q;
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      keeper_q <= '0;
      sticky_q <= 1'b0;
    end else begin
      keeper_q <= bus_d;
      sticky_q <= multi_d | (sticky_q & ~err_clr);
    end
  end
  assign contention_sticky = sticky_q;
  if (REG_OUT != 0) begin : g_reg
    logic [WIDTH-1:0] bus_q;
    logic valid_q, cont_q;
    logic [SW-1:0] idx_q;
    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        bus_q <= '0;
        valid_q <= 1'b0;
        idx_q <= '0;
        cont_q <= 1'b0;
      end else begin
        bus_q <= bus_d;
        valid_q <= any_d;
        idx_q <= idx_d;
        cont_q <= multi_d;
      end
    end
    assign bus_out = bus_q;
    assign bus_valid = valid_q;
    assign sel_idx = idx_q;
    assign contention = cont_q;
  end else begin : g_comb
    assign bus_out = bus_d;
    assign bus_valid = any_d;
    assign sel_idx = idx_d;
    assign contention = multi_d;
  end
`ifdef GATED_BUS_ERRCNT_EN
  logic [15:0] cnt_q, cnt_d;
  // clear with simultaneous contention loads 1 so that event is not lost
  assign cnt_d = err_clr ? {15'd0, multi_d} : (multi_d && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign err_count = cnt_q;
`endif
endmodule

// File: tb/tb_gated_bus.sv
// tb_gated_bus: randomized and directed checks of gated_bus (REG_OUT=0 and 1) against a behavioural model
module tb_gated_bus;
  logic clk = 0, rst = 1, err_clr = 0;
  logic [3:0] gate = '0;
  logic [3:0][15:0] src = '0;
  logic [15:0] b0, b1;
  logic v0, v1, c0, c1, s0, s1;
  logic [1:0] i0, i1;
`ifdef GATED_BUS_ERRCNT_EN
  logic [15:0] e0, e1;
`endif
  int nchk = 0, nfail = 0;
  logic [15:0] m_keep, m_rbus;
  logic m_rvalid, m_rcont, m_sticky;
  int m_ridx, m_cnt;
  always #5 clk = ~clk;
  gated_bus #(.REG_OUT(0)) u0 (
    .Clk(clk), .Reset(rst), .gate(gate), .src_data(src), .err_clr(err_clr),
    .bus_out(b0), .bus_valid(v0), .sel_idx(i0), .contention(c0), .contention_sticky(s0)
`ifdef GATED_BUS_ERRCNT_EN
    , .err_count(e0)
`endif
  );
  gated_bus #(.REG_OUT(1)) u1 (
    .Clk(clk), .Reset(rst), .gate(gate), .src_data(src), .err_clr(err_clr),
    .bus_out(b1), .bus_valid(v1), .sel_idx(i1), .contention(c1), .contention_sticky(s1)
`ifdef GATED_BUS_ERRCNT_EN
    , .err_count(e1)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_keep = 0; m_rbus = 0; m_rvalid = 0; m_rcont = 0; m_ridx = 0; m_sticky = 0; m_cnt = 0;
  endtask
  task automatic check_state();
    chk("r_bus", b1, m_rbus);
    chk("r_valid", v1, m_rvalid);
    chk("r_idx", i1, m_ridx);
    chk("r_cont", c1, m_rcont);
    chk("sticky0", s0, m_sticky);
    chk("sticky1", s1, m_sticky);
`ifdef GATED_BUS_ERRCNT_EN
    chk("cnt0", e0, m_cnt);
    chk("cnt1", e1, m_cnt);
`endif
  endtask
  task automatic cycle(input logic [3:0] g, input logic [3:0][15:0] d, input logic clr);
    int n, idx;
    logic [15:0] bus;
    @(negedge clk);
    check_state();
    gate = g; src = d; err_clr = clr;
    #1;
    n = 0; idx = 0;
    for (int k = 3; k >= 0; k--) if (g[k]) begin n++; idx = k; end
    bus = (n > 0) ? d[idx] : m_keep;
    chk("c_bus", b0, bus);
    chk("c_valid", v0, n > 0);
    chk("c_idx", i0, idx);
    chk("c_cont", c0, n > 1);
    m_keep = bus; m_rbus = bus; m_rvalid = n > 0; m_ridx = idx; m_rcont = n > 1;
    m_sticky = (n > 1) || (m_sticky && !clr);
    m_cnt = clr ? (n > 1 ? 1 : 0) : (n > 1 && m_cnt < 65535) ? m_cnt + 1 : m_cnt;
  endtask
  initial begin
    logic [3:0][15:0] d;
    model_reset();
    #1;
    chk("rst_bus0", b0, 0);
    chk("rst_bus1", b1, 0);
    chk("rst_valid1", v1, 0);
    chk("rst_sticky", s0, 0);
    @(negedge clk); @(negedge clk);
    rst = 0;
    d = '0; d[2] = 16'h3000;
    cycle(4'b0100, d, 0);
    chk("dir_bus_same", b0, 16'h3000);
    for (int k = 0; k < 3; k++) begin
      cycle(4'b0000, d, 0);
      chk("dir_hold", b0, 16'h3000);
      chk("dir_hold_v", v0, 0);
    end
    d[1] = 16'hAAAA; d[3] = 16'h5555;
    cycle(4'b1010, d, 0);
    chk("dir_pri", b0, 16'hAAAA);
    chk("dir_pri_idx", i0, 1);
    cycle(4'b0000, d, 1);
    cycle(4'b0000, d, 0);
    chk("dir_sticky_clr", s0, 0);
    for (int k = 0; k < 3; k++) cycle(4'b0011, d, 0);
    @(negedge clk);
`ifdef GATED_BUS_ERRCNT_EN
    chk("dir_cnt3", e0, 3);
`endif
    cycle(4'b1100, d, 1);
    @(negedge clk);
    chk("dir_sticky_set_wins", s0, 1);
`ifdef GATED_BUS_ERRCNT_EN
    chk("dir_cnt1", e0, 1);
`endif
    for (int k = 0; k < 300; k++) begin
      for (int j = 0; j < 4; j++) d[j] = 16'($urandom);
      cycle(($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom), d, $urandom_range(0, 7) == 0);
    end
`ifdef GATED_BUS_ERRCNT_EN
    cycle(4'b0000, d, 1);
    for (int k = 0; k < 65540; k++) cycle(4'b0101, d, 0);
    @(negedge clk);
    chk("dir_sat", e0, 16'hFFFF);
    cycle(4'b1111, d, 0);
    @(negedge clk);
    chk("dir_sat_hold", e1, 16'hFFFF);
`endif
    d = '0; d[0] = 16'h1234; d[3] = 16'h4321;
    cycle(4'b1001, d, 0);
    @(negedge clk);
    gate = 4'b1000;
    #2 rst = 1;
    #1;
    chk("arst_bus1", b1, 0);
    chk("arst_valid1", v1, 0);
    chk("arst_idx1", i1, 0);
    chk("arst_cont1", c1, 0);
    chk("arst_sticky", s0, 0);
    gate = 4'b0000;
    #1 chk("arst_keep0", b0, 0);
    rst = 0;
    model_reset();
    d[2] = 16'hBEEF;
    cycle(4'b0100, d, 0);
    for (int k = 0; k < 20; k++) begin
      for (int j = 0; j < 4; j++) d[j] = 16'($urandom);
      cycle(4'($urandom), d, 0);
    end
    @(negedge clk);
    check_state();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end
endmodule
